uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO and per-frame runtime line configuration: data width, parity mode, stop-bit count and baud divisor. Producers push words over a valid/ready handshake. The block serialises them back-to-back onto `tx_o` with no idle gap while words remain queued. It replaces the fixed-rate, fixed 8N1, single-buffer transmitter in designs that need other line formats or burst writes.

## Interface
- `DataWidth`, default 8: data bits per frame; legal range 5..9.
- `FifoDepth`, default 4: FIFO entries; power of two, at least 2.
- `DivWidth`, default 16: width of `divisor_i`.

- `clk_i`  in  1: sole clock; all logic is on its rising edge.
- `rst_i`  in  1: reset; asynchronous, active-high.
- `valid_i`  in  1: producer has a word on `data_i`.
- `ready_o`  out  1: FIFO can accept a word; equals not-full.
- `data_i`  in  DataWidth: word to transmit, sent LSB first.
- `divisor_i`  in  DivWidth: clock cycles per bit; 0 is treated as 1.
- `parity_i`  in  2: parity mode. 00 = none, 01 = odd, 10 = even, 11 = mark (constant 1).
- `stop2_i`  in  1: 0 = one stop bit, 1 = two stop bits.
- `tx_o`  out  1: serial line, registered; idles at 1.
- `busy_o`  out  1: a frame is on the line.
- `level_o`  out  $clog2(FifoDepth)+1: FIFO occupancy, 0..FifoDepth.

## Operation
- A push occurs on an edge where `valid_i && ready_o`. The word is written at the tail and `level_o` increments.
- A pop occurs on an edge where the transmitter is Idle, or finishing its last stop bit, and `level_o > 0`.
- On a pop the transmitter loads the head word and latches `divisor_i`, `parity_i` and `stop2_i`. These latched values govern the whole frame; changes to the inputs mid-frame have no effect.
- Push and pop on the same edge leave `level_o` unchanged.
- A pop cannot serve a word pushed on the same edge; the FIFO is not bypassed.
- Frame order:
  - Start bit: 0.
  - `DataWidth` data bits, LSB first.
  - Parity bit, only if mode is not 00.
  - One stop bit (1), or two if `stop2_i` was set.
- Parity values:
  - Odd: the total number of ones in data plus parity is odd.
  - Even: that total is even.
  - Mark: the parity bit is always 1.
- State machine: Idle -> Start -> Data -> Parity -> Stop1 -> Stop2.
  - Parity is skipped when mode is 00.
  - Stop2 is skipped when two stop bits are not selected.
  - From the final stop state: go to Start if a pop occurs, else to Idle.
- Bit counter: counts the data bits 0..DataWidth-1.
- Baud counter: loads D-1 at each bit start and decrements to 0; the bit ends on the edge where it reads 0. D is the latched divisor, with 0 treated as 1.
- `busy_o` is 1 in every state except Idle.

## Timing
- Reset values: `tx_o`=1, `ready_o`=1, `busy_o`=0, `level_o`=0.
- Reset empties the FIFO and aborts any frame in progress; the line returns to 1 immediately, asynchronously.
- From Idle with the FIFO empty:
  - Push at edge N.
  - Pop at edge N+1; `tx_o`=0 and `busy_o`=1 after N+1.
- Every bit, start and stop bits included, lasts exactly D cycles.
- Frame length: D × (1 + DataWidth + P + S) cycles, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- Back-to-back: if the FIFO is non-empty when the last stop bit ends, the next start bit begins on that same edge. There is no idle cycle and `busy_o` stays 1.
- `ready_o` is 0 only while `level_o == FifoDepth`. A pop on that edge makes `ready_o` 1 after the edge.
- `valid_i` while `ready_o`=0 is ignored. The producer holds `data_i` until the push is accepted.

## Test plan
- **8N1, D=4, push 0x55:** `tx_o` bits are 0,1,0,1,0,1,0,1,0,1, each 4 cycles. `busy_o` is high for 40 cycles, then `tx_o`=1 and `busy_o`=0.
- **Parity modes, DataWidth=8, D=2, data 0x07:**
  - Even: parity bit 1.
  - Odd: parity bit 0.
  - Mark: parity bit 1.
  - Each frame is 22 cycles.
- **Two stop bits, D=3, push 0xFF:** stop level (1) lasts 6 cycles before `busy_o` falls. Also run with `divisor_i`=0: every bit is 1 cycle.
- **Burst, FifoDepth=4, D=100, `valid_i` held 6 cycles from empty:**
  - Five words are accepted.
  - `ready_o`=0 on the 6th cycle with `level_o`=4.
  - All five frames go out contiguously with no idle gap.
- **Mid-frame config change:** change `divisor_i` from 4 to 8 and `parity_i` from 00 to 10 during data bit 3. The current frame finishes at D=4, no parity. The next queued frame uses D=8 with even parity.
- **Reset mid-frame:**
  - Assert `rst_i` asynchronously during data bit 2 with 2 words queued: `tx_o`=1, `busy_o`=0, `level_o`=0 and `ready_o`=1 immediately.
  - After release, nothing is transmitted until a new push.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO and per-frame line configuration.
// Line settings are latched at each pop and hold for the whole frame.
module uart_tx_fifo #(
    parameter int DataWidth = 8,
    parameter int FifoDepth = 4,
    parameter int DivWidth  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [DataWidth-1:0]        data_i,
    input  logic [DivWidth-1:0]         divisor_i,
    input  logic [1:0]                  parity_i,
    input  logic                        stop2_i,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(FifoDepth):0]  level_o
);

    localparam int AW = $clog2(FifoDepth);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DataWidth);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2
    } state_t;

    logic [DataWidth-1:0] mem [FifoDepth];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level;

    state_t               state;
    logic [DataWidth-1:0] shift;
    logic [BW-1:0]        bit_cnt;
    logic [DivWidth-1:0]  baud;
    logic [DivWidth-1:0]  div_q;
    logic                 par_en;
    logic                 par_bit;
    logic                 stop2_q;

    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 last_stop;
    logic                 par_calc;
    logic [DataWidth-1:0] head;
    logic [DivWidth-1:0]  div_eff;

    assign head      = mem[rd_ptr];
    assign ready_o   = (level != LW'(FifoDepth));
    assign level_o   = level;
    assign push      = valid_i && ready_o;
    assign bit_end   = (baud == '0);
    assign last_stop = bit_end &&
                       ((state == STOP1 && !stop2_q) ||
                        (state == STOP2));
    assign pop       = (level != '0) &&
                       ((state == IDLE) || last_stop);
    assign div_eff   = (divisor_i == '0) ? DivWidth'(1)
                                         : divisor_i;

    always_comb begin
        par_calc = 1'b1;
        unique case (parity_i)
            2'b01:   par_calc = ~^head;
            2'b10:   par_calc = ^head;
            default: par_calc = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
            shift   <= '0;
            bit_cnt <= '0;
            baud    <= '0;
            div_q   <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            stop2_q <= 1'b0;
        end else if (pop) begin
            state   <= START;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
            shift   <= head;
            bit_cnt <= '0;
            baud    <= div_eff - DivWidth'(1);
            div_q   <= div_eff;
            par_en  <= (parity_i != 2'b00);
            par_bit <= par_calc;
            stop2_q <= stop2_i;
        end else if (state != IDLE) begin
            if (!bit_end) begin
                baud <= baud - DivWidth'(1);
            end else begin
                baud <= div_q - DivWidth'(1);
                unique case (state)
                    START: begin
                        state   <= DATA;
                        tx_o    <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == BW'(DataWidth - 1)) begin
                            if (par_en) begin
                                state <= PARITY;
                                tx_o  <= par_bit;
                            end else begin
                                state <= STOP1;
                                tx_o  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            tx_o    <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                    PARITY: begin
                        state <= STOP1;
                        tx_o  <= 1'b1;
                    end
                    STOP1: begin
                        if (stop2_q) begin
                            state <= STOP2;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                    STOP2: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        tx_o   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed frame table, corner sequences
// and randomized traffic against a queue-based line model.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [7:0]  data = 8'h00;
    logic [15:0] div = 16'd4;
    logic [1:0]  par = 2'b00;
    logic        stop2 = 1'b0;
    logic        tx;
    logic        busy;
    logic [2:0]  level;

    int total = 0;
    int passed = 0;

    logic [7:0] mq[$];
    bit         lineq[$];
    logic       e_tx = 1'b1;
    logic       e_busy = 1'b0;
    bit         m_acc = 1'b0;
    logic       smp [0:8191];

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic [1:0]  par;
        logic        stop2;
        int          len;
        logic        pbit;
    } vec_t;

    vec_t vt [7];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DataWidth(8),
        .FifoDepth(4),
        .DivWidth(16)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (valid),
        .ready_o  (ready),
        .data_i   (data),
        .divisor_i(div),
        .parity_i (par),
        .stop2_i  (stop2),
        .tx_o     (tx),
        .busy_o   (busy),
        .level_o  (level)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        else
            passed++;
    endtask

    // Line model: a frame becomes a list of per-cycle line levels.
    task automatic model_edge();
        int   pre;
        int   d;
        logic [7:0] w;
        bit   fb[$];
        m_acc = 1'b0;
        if (rst) begin
            mq.delete();
            lineq.delete();
            e_tx = 1'b1;
            e_busy = 1'b0;
            return;
        end
        pre = mq.size();
        m_acc = valid && (pre < 4);
        if (lineq.size() == 0 && pre > 0) begin
            w = mq.pop_front();
            d = (div == 16'd0) ? 1 : int'(div);
            fb.push_back(1'b0);
            for (int i = 0; i < 8; i++) fb.push_back(w[i]);
            case (par)
                2'b01:   fb.push_back(~^w);
                2'b10:   fb.push_back(^w);
                2'b11:   fb.push_back(1'b1);
                default: ;
            endcase
            fb.push_back(1'b1);
            if (stop2) fb.push_back(1'b1);
            foreach (fb[i])
                for (int k = 0; k < d; k++) lineq.push_back(fb[i]);
        end
        if (m_acc) mq.push_back(data);
        if (lineq.size() > 0) begin
            e_tx = lineq.pop_front();
            e_busy = 1'b1;
        end else begin
            e_tx = 1'b1;
            e_busy = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("tx_o", tx, e_tx);
        chk("busy_o", busy, e_busy);
        chk("level_o", level, mq.size());
        chk("ready_o", ready, mq.size() < 4);
    endtask

    task automatic run_busy(input int chg_at, input logic [15:0] ndiv,
                            input logic [1:0] npar, output int n);
        int guard;
        guard = 0;
        n = 0;
        while (guard < 20000) begin
            step();
            guard++;
            if (m_acc) valid = 1'b0;
            if (busy) begin
                smp[n] = tx;
                n++;
                if (n == chg_at) begin
                    div = ndiv;
                    par = npar;
                end
            end else if (n > 0) begin
                break;
            end
        end
        if (guard >= 20000) begin
            total++;
            $display("FAIL run_busy timeout: got busy=%0b n=%0d", busy, n);
        end
    endtask

    initial begin
        int n;
        int d;
        int acc;
        int cnt;

        vt[0] = '{8'h55, 16'd4, 2'b00, 1'b0, 40, 1'b0};
        vt[1] = '{8'h07, 16'd2, 2'b10, 1'b0, 22, 1'b1};
        vt[2] = '{8'h07, 16'd2, 2'b01, 1'b0, 22, 1'b0};
        vt[3] = '{8'h07, 16'd2, 2'b11, 1'b0, 22, 1'b1};
        vt[4] = '{8'hFF, 16'd3, 2'b00, 1'b1, 33, 1'b0};
        vt[5] = '{8'hFF, 16'd0, 2'b00, 1'b1, 11, 1'b0};
        vt[6] = '{8'hA3, 16'd5, 2'b01, 1'b1, 60, 1'b1};

        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", ready, 1);
        step();
        rst = 1'b0;
        repeat (2) step();

        foreach (vt[i]) begin
            data = vt[i].data;
            div = vt[i].div;
            par = vt[i].par;
            stop2 = vt[i].stop2;
            valid = 1'b1;
            run_busy(-1, 16'd0, 2'b00, n);
            chk("frame_len", n, vt[i].len);
            d = (vt[i].div == 16'd0) ? 1 : int'(vt[i].div);
            if (vt[i].par != 2'b00)
                chk("parity_bit", smp[9 * d], vt[i].pbit);
            if (vt[i].stop2)
                chk("stop2_level", smp[n - 2 * d], 1);
            chk("idle_tx", tx, 1);
        end

        div = 16'd100;
        par = 2'b00;
        stop2 = 1'b0;
        data = 8'h11;
        valid = 1'b1;
        acc = 0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) begin
                chk("burst_ready", ready, 0);
                chk("burst_level", level, 4);
            end
            if (ready) acc++;
            step();
            if (busy) cnt++;
            if (m_acc) data = data + 8'h11;
        end
        valid = 1'b0;
        chk("burst_accepted", acc, 5);
        run_busy(-1, 16'd0, 2'b00, n);
        chk("burst_busy_len", cnt + n, 5000);

        div = 16'd4;
        par = 2'b00;
        data = 8'hA5;
        valid = 1'b1;
        step();
        data = 8'h03;
        run_busy(18, 16'd8, 2'b10, n);
        chk("cfg_total_len", n, 128);
        chk("cfg_a_stop", smp[39], 1);
        chk("cfg_b_start", smp[40], 0);
        chk("cfg_b_start_end", smp[47], 0);
        chk("cfg_b_parity", smp[112], 0);
        chk("cfg_b_stop", smp[120], 1);

        div = 16'd4;
        par = 2'b00;
        data = 8'h3C;
        valid = 1'b1;
        step();
        data = 8'hC3;
        step();
        data = 8'h5A;
        step();
        valid = 1'b0;
        repeat (12) step();
        chk("pre_rst_level", level, 2);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_ready", ready, 1);
        mq.delete();
        lineq.delete();
        e_tx = 1'b1;
        e_busy = 1'b0;
        step();
        rst = 1'b0;
        repeat (40) step();
        chk("post_rst_idle", busy, 0);

        for (int r = 0; r < 4000; r++) begin
            if (r < 2000)
                valid = ($urandom_range(0, 3) != 0);
            else
                valid = ($urandom_range(0, 7) == 0);
            div = 16'($urandom_range(0, 3));
            par = 2'($urandom);
            stop2 = 1'($urandom);
            step();
            if (m_acc) data = 8'($urandom);
        end
        valid = 1'b0;
        repeat (200) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
